// File: rtl/ws2812_matrix_drv.sv
// WS2812 matrix driver: walks an M x N frame buffer in chain order, scales
// each pixel by a global brightness and serialises it as GRB with WS2812 bit
// timing, followed by the reset latch.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for refresh expiry (MODE=0) or frame_go (MODE=1)
// S_FETCH0 | read strobe for pixel 0 is on the bus
// S_LOAD   | pixel 0 data valid; scale and load the shifter
// S_BIT_HI | data line high for T0H/T1H clocks
// S_BIT_LO | data line low for the rest of the bit; next pixel prefetch
// S_LATCH  | data line low for TRST clocks, then frame_done
module ws2812_matrix_drv #(
  parameter int CLK_FRE    = 50_000_000,
  parameter int WS2812_M   = 8,
  parameter int WS2812_N   = 8,
  parameter int SERPENTINE = 1,
  parameter int MODE       = 0,
  parameter int REFRESH_HZ = 120,
  parameter int T0H_NS     = 400,
  parameter int T1H_NS     = 800,
  parameter int BIT_NS     = 1250,
  parameter int RESET_US   = 300,
  parameter int ADDR_W     = $clog2(WS2812_M * WS2812_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_go,
  input  logic [7:0]        brightness,
  output logic              pix_rd_en,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_rd_data,
  output logic              busy,
  output logic              frame_done,
  output logic              ws2812_di
);

  localparam int CLK_NS  = 1_000_000_000 / CLK_FRE;
  localparam int T0H     = T0H_NS / CLK_NS;
  localparam int T1H     = T1H_NS / CLK_NS;
  localparam int TBIT    = BIT_NS / CLK_NS;
  localparam int TRST    = RESET_US * 1000 / CLK_NS;
  localparam int TFRM    = CLK_FRE / REFRESH_HZ;
  localparam int NPIX    = WS2812_M * WS2812_N;
  localparam int CNT_MAX = (TRST > TBIT) ? TRST : TBIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FRM_W   = $clog2(TFRM + 1);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH0,
    S_LOAD,
    S_BIT_HI,
    S_BIT_LO,
    S_LATCH
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [4:0]        bit_q, bit_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [23:0]       stage_q, stage_d;
  logic [7:0]        bright_q, bright_d;
  logic [FRM_W-1:0]  frm_cnt_q, frm_cnt_d;
  logic              rd_vld_q, rd_vld_d;
  logic              pix_rd_en_q, pix_rd_en_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              di_q, di_d;

  logic [15:0]       scale_k;
  logic [15:0]       prod_r, prod_g, prod_b;
  logic [23:0]       scaled_grb;
  logic              frm_expired;
  logic              start_frame;

  // Chain position to frame-buffer address; odd rows reversed when serpentine.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] p);
    int row;
    int col;
    row = int'(p) / WS2812_N;
    col = int'(p) % WS2812_N;
    if (SERPENTINE != 0 && (row % 2) == 1) begin
      col = WS2812_N - 1 - col;
    end
    return ADDR_W'(row * WS2812_N + col);
  endfunction

  // Down-counter preload for the high phase of a bit.
  function automatic logic [CNT_W-1:0] hi_load(input logic b);
    return b ? CNT_W'(T1H - 1) : CNT_W'(T0H - 1);
  endfunction

  // Down-counter preload for the low phase, completing TBIT.
  function automatic logic [CNT_W-1:0] lo_load(input logic b);
    return b ? CNT_W'(TBIT - T1H - 1) : CNT_W'(TBIT - T0H - 1);
  endfunction

  // Brightness scaling of the RAM word {R,G,B} into wire order {G,R,B}.
  always_comb begin
    scale_k    = {8'd0, bright_q} + 16'd1;
    prod_r     = {8'd0, pix_rd_data[23:16]} * scale_k;
    prod_g     = {8'd0, pix_rd_data[15:8]}  * scale_k;
    prod_b     = {8'd0, pix_rd_data[7:0]}   * scale_k;
    scaled_grb = {prod_g[15:8], prod_r[15:8], prod_b[15:8]};
  end

  // Free-running refresh timer (continuous mode) and frame start decision.
  always_comb begin
    frm_cnt_d   = '0;
    frm_expired = 1'b0;
    if (MODE == 0) begin
      frm_expired = (frm_cnt_q == '0);
      frm_cnt_d   = frm_expired ? FRM_W'(TFRM - 1) : frm_cnt_q - FRM_W'(1);
    end
    // a frame_go landing on the frame_done cycle is intentionally lost
    start_frame = (MODE == 0) ? frm_expired : (frame_go && !frame_done_q);
  end

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    pix_d        = pix_q;
    bit_d        = bit_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    stage_d      = stage_q;
    bright_d     = bright_q;
    rd_vld_d     = pix_rd_en_q;
    pix_rd_en_d  = 1'b0;
    pix_addr_d   = pix_addr_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    di_d         = di_q;

    // prefetched pixel arrives one cycle after its strobe
    if (rd_vld_q && state_q == S_BIT_LO) begin
      stage_d = scaled_grb;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_frame) begin
          state_d     = S_FETCH0;
          bright_d    = brightness;
          busy_d      = 1'b1;
          pix_d       = '0;
          pix_rd_en_d = 1'b1;
          pix_addr_d  = addr_of('0);
          di_d        = 1'b0;
        end
      end
      S_FETCH0: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d = scaled_grb;
        bit_d   = 5'd0;
        cnt_d   = hi_load(scaled_grb[23]);
        di_d    = 1'b1;
        state_d = S_BIT_HI;
      end
      S_BIT_HI: begin
        if (cnt_q == '0) begin
          state_d = S_BIT_LO;
          di_d    = 1'b0;
          cnt_d   = lo_load(shift_q[23]);
          if (bit_q == 5'd23 && pix_q != LAST_PIX) begin
            pix_rd_en_d = 1'b1;
            pix_addr_d  = addr_of(pix_q + ADDR_W'(1));
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_BIT_LO: begin
        if (cnt_q == '0) begin
          if (bit_q != 5'd23) begin
            shift_d = {shift_q[22:0], 1'b0};
            bit_d   = bit_q + 5'd1;
            cnt_d   = hi_load(shift_q[22]);
            di_d    = 1'b1;
            state_d = S_BIT_HI;
          end else if (pix_q == LAST_PIX) begin
            cnt_d   = CNT_W'(TRST - 1);
            state_d = S_LATCH;
          end else begin
            // staged pixel goes straight out, no inter-pixel gap
            shift_d = stage_q;
            pix_d   = pix_q + ADDR_W'(1);
            bit_d   = 5'd0;
            cnt_d   = hi_load(stage_q[23]);
            di_d    = 1'b1;
            state_d = S_BIT_HI;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_LATCH: begin
        if (cnt_q == '0) begin
          state_d      = S_IDLE;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        di_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the data line immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pix_q        <= '0;
      bit_q        <= '0;
      cnt_q        <= '0;
      shift_q      <= '0;
      stage_q      <= '0;
      bright_q     <= '0;
      frm_cnt_q    <= '0;
      rd_vld_q     <= 1'b0;
      pix_rd_en_q  <= 1'b0;
      pix_addr_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      di_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_q        <= pix_d;
      bit_q        <= bit_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      stage_q      <= stage_d;
      bright_q     <= bright_d;
      frm_cnt_q    <= frm_cnt_d;
      rd_vld_q     <= rd_vld_d;
      pix_rd_en_q  <= pix_rd_en_d;
      pix_addr_q   <= pix_addr_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      di_q         <= di_d;
    end
  end

  assign pix_rd_en  = pix_rd_en_q;
  assign pix_addr   = pix_addr_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign ws2812_di  = di_q;

endmodule

// File: tb/tb_ws2812_matrix_drv.sv
// Bench for ws2812_matrix_drv: a continuous-mode serpentine instance (a) and
// a triggered row-major instance (b), each with a 1-cycle-latency RAM model
// and a line decoder that rebuilds the 24-bit wire words from pulse widths.
module tb_ws2812_matrix_drv;

  localparam int T0H_C  = 20;
  localparam int T1H_C  = 40;
  localparam int TBIT_C = 62;
  localparam int TRST_C = 100;
  localparam int TFRM_A = 10000;

  typedef struct {
    logic [7:0]  br;
    logic [23:0] rgb;
    logic [23:0] grb;
  } vec_t;

  logic clk;
  logic rst_a_n, rst_b_n;
  logic frame_go_a, frame_go_b;
  logic [7:0] br_a, br_b;
  logic rd_en_a, rd_en_b;
  logic [2:0] addr_a, addr_b;
  logic [23:0] rdata_a, rdata_b;
  logic busy_a, busy_b, fd_a, fd_b, di_a, di_b;

  logic [23:0] mem_a [8];
  logic [23:0] mem_b [8];

  int n_chk, n_fail, cyc, rel_cyc;
  vec_t tbl [24];

  ws2812_matrix_drv #(
    .CLK_FRE(50_000_000), .WS2812_M(2), .WS2812_N(3), .SERPENTINE(1), .MODE(0),
    .REFRESH_HZ(5000), .T0H_NS(400), .T1H_NS(800), .BIT_NS(1250), .RESET_US(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_a_n), .frame_go(frame_go_a), .brightness(br_a),
    .pix_rd_en(rd_en_a), .pix_addr(addr_a), .pix_rd_data(rdata_a),
    .busy(busy_a), .frame_done(fd_a), .ws2812_di(di_a)
  );

  ws2812_matrix_drv #(
    .CLK_FRE(50_000_000), .WS2812_M(2), .WS2812_N(3), .SERPENTINE(0), .MODE(1),
    .REFRESH_HZ(120), .T0H_NS(400), .T1H_NS(800), .BIT_NS(1250), .RESET_US(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_b_n), .frame_go(frame_go_b), .brightness(br_b),
    .pix_rd_en(rd_en_b), .pix_addr(addr_b), .pix_rd_data(rdata_b),
    .busy(busy_b), .frame_done(fd_b), .ws2812_di(di_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en_a) rdata_a <= mem_a[addr_a];
    if (rd_en_b) rdata_b <= mem_b[addr_b];
  end

  // line decoder and bus logger, index 0 = dut_a, 1 = dut_b
  logic [1:0] di_w, rst_w, rd_w, fd_w, busy_w;
  logic [2:0] addr_w [2];
  assign di_w   = {di_b, di_a};
  assign rst_w  = {rst_b_n, rst_a_n};
  assign rd_w   = {rd_en_b, rd_en_a};
  assign fd_w   = {fd_b, fd_a};
  assign busy_w = {busy_b, busy_a};
  assign addr_w[0] = addr_a;
  assign addr_w[1] = addr_b;

  logic        prev_di [2];
  logic        prev_busy [2];
  int          hi_len [2], lo_len [2], bitc [2];
  int          words_n [2], alog_n [2], fd_n [2], rise_n [2];
  int          bad_hi [2], bad_per [2], n_per [2];
  logic [23:0] sh [2];
  logic [23:0] words [2][64];
  int          alog [2][64];
  int          rise_cyc [2][16];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      prev_busy[k] <= busy_w[k];
      if (busy_w[k] && !prev_busy[k] && rise_n[k] < 16) begin
        rise_cyc[k][rise_n[k]] <= cyc;
        rise_n[k] <= rise_n[k] + 1;
      end
      if (fd_w[k]) fd_n[k] <= fd_n[k] + 1;
      if (!rst_w[k]) begin
        prev_di[k] <= 1'b0;
        hi_len[k]  <= 0;
        lo_len[k]  <= 100000;
        bitc[k]    <= 0;
        sh[k]      <= '0;
        words_n[k] <= 0;
        alog_n[k]  <= 0;
      end else begin
        prev_di[k] <= di_w[k];
        if (rd_w[k] && alog_n[k] < 64) begin
          alog[k][alog_n[k]] <= int'(addr_w[k]);
          alog_n[k] <= alog_n[k] + 1;
        end
        if (di_w[k]) begin
          if (!prev_di[k]) begin
            hi_len[k] <= 1;
            if (lo_len[k] <= 200) begin
              n_per[k] <= n_per[k] + 1;
              if (hi_len[k] + lo_len[k] != TBIT_C) bad_per[k] <= bad_per[k] + 1;
            end
          end else begin
            hi_len[k] <= hi_len[k] + 1;
          end
        end else begin
          if (prev_di[k]) begin
            lo_len[k] <= 1;
            if (hi_len[k] != T0H_C && hi_len[k] != T1H_C) bad_hi[k] <= bad_hi[k] + 1;
            sh[k] <= {sh[k][22:0], (hi_len[k] == T1H_C)};
            if (bitc[k] == 23) begin
              bitc[k] <= 0;
              if (words_n[k] < 64) begin
                words[k][words_n[k]] <= {sh[k][22:0], (hi_len[k] == T1H_C)};
                words_n[k] <= words_n[k] + 1;
              end
            end else begin
              bitc[k] <= bitc[k] + 1;
            end
          end else begin
            lo_len[k] <= lo_len[k] + 1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // continuous serpentine instance: order, timing, refresh period, reset
  task automatic seq_a();
    int t;
    int exp_addr [6];
    logic [23:0] exp_word [6];
    exp_addr = '{0, 1, 2, 5, 4, 3};
    exp_word = '{24'h000000, 24'hFFFFFF, 24'h221133, 24'hBBAACC, 24'h887799, 24'h554466};
    t = 0;
    while (!fd_a && t < 12000) begin @(negedge clk); t++; end
    check("a first frame_done", 32'(fd_a), 1);
    check("a strobe count", alog_n[0], 6);
    for (int i = 0; i < 6; i++) check($sformatf("a addr[%0d]", i), alog[0][i], exp_addr[i]);
    check("a word count", words_n[0], 6);
    for (int i = 0; i < 6; i++) check($sformatf("a word[%0d]", i), words[0][i], exp_word[i]);
    check("a bad high widths", bad_hi[0], 0);
    check("a bad bit periods", bad_per[0], 0);
    check("a periods checked", n_per[0], 143);
    t = 0;
    while (rise_n[0] < 2 && t < 12000) begin @(negedge clk); t++; end
    check("a first start after reset", rise_cyc[0][0], rel_cyc + 1);
    check("a frame start spacing", rise_cyc[0][1] - rise_cyc[0][0], TFRM_A);
    repeat (300) @(negedge clk);
    t = 0;
    while (!di_a && t < 200) begin @(negedge clk); t++; end
    check("a di high before reset", 32'(di_a), 1);
    #2 rst_a_n = 1'b0;
    #1;
    check("a di on reset", 32'(di_a), 0);
    check("a outputs on reset", {27'd0, busy_a, rd_en_a, fd_a, 2'd0} | {29'd0, addr_a}, 0);
    repeat (3) @(negedge clk);
    rst_a_n = 1'b1;
    @(negedge clk);
    check("a busy after restart", 32'(busy_a), 1);
    t = 0;
    while (!fd_a && t < 12000) begin @(negedge clk); t++; end
    check("a restart frame_done", 32'(fd_a), 1);
    check("a restart strobes", alog_n[0], 6);
    check("a restart addr0", alog[0][0], 0);
    check("a restart addr1", alog[0][1], 1);
    check("a restart word0", words[0][0], 24'h000000);
    check("a restart word1", words[0][1], 24'hFFFFFF);
    check("a restart bad high", bad_hi[0], 0);
  endtask

  // triggered row-major instance: table-driven scaling over four frames
  task automatic seq_b();
    int t, base_w, base_a, base_fd;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 6; i++) mem_b[i] = tbl[f*6+i].rgb;
      br_b    = tbl[f*6].br;
      base_w  = words_n[1];
      base_a  = alog_n[1];
      base_fd = fd_n[1];
      frame_go_b = 1'b1;
      @(negedge clk);
      frame_go_b = 1'b0;
      check($sformatf("b f%0d busy at start", f), 32'(busy_b), 1);
      if (f == 0) begin
        repeat (3000) @(negedge clk);
        frame_go_b = 1'b1;
        @(negedge clk);
        frame_go_b = 1'b0;
      end
      t = 0;
      while (!fd_b && t < 12000) begin @(negedge clk); t++; end
      check($sformatf("b f%0d frame_done", f), 32'(fd_b), 1);
      check($sformatf("b f%0d busy at done", f), 32'(busy_b), 0);
      check($sformatf("b f%0d latch low", f),
            32'(lo_len[1] >= TRST_C && lo_len[1] <= TRST_C + TBIT_C), 1);
      if (f == 3) begin
        frame_go_b = 1'b1;
        @(negedge clk);
        frame_go_b = 1'b0;
      end
      repeat (300) @(negedge clk);
      check($sformatf("b f%0d idle after", f), 32'(busy_b), 0);
      check($sformatf("b f%0d done pulses", f), fd_n[1] - base_fd, 1);
      check($sformatf("b f%0d strobes", f), alog_n[1] - base_a, 6);
      check($sformatf("b f%0d words", f), words_n[1] - base_w, 6);
      for (int i = 0; i < 6; i++) begin
        check($sformatf("b f%0d addr[%0d]", f, i), alog[1][base_a+i], i);
        check($sformatf("b f%0d word[%0d]", f, i), words[1][base_w+i], tbl[f*6+i].grb);
      end
    end
    check("b bad high widths", bad_hi[1], 0);
    check("b bad bit periods", bad_per[1], 0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    tbl[0]  = '{8'h7F, 24'hFF8040, 24'h407F20};
    tbl[1]  = '{8'h7F, 24'h000000, 24'h000000};
    tbl[2]  = '{8'h7F, 24'hFFFFFF, 24'h7F7F7F};
    tbl[3]  = '{8'h7F, 24'h123456, 24'h1A092B};
    tbl[4]  = '{8'h7F, 24'h010203, 24'h010001};
    tbl[5]  = '{8'h7F, 24'h80FF01, 24'h7F4000};
    tbl[6]  = '{8'hFF, 24'hFF8040, 24'h80FF40};
    tbl[7]  = '{8'hFF, 24'h123456, 24'h341256};
    tbl[8]  = '{8'hFF, 24'hA5A5A5, 24'hA5A5A5};
    tbl[9]  = '{8'hFF, 24'h0F00F0, 24'h000FF0};
    tbl[10] = '{8'hFF, 24'h00FF00, 24'hFF0000};
    tbl[11] = '{8'hFF, 24'h000001, 24'h000001};
    tbl[12] = '{8'h01, 24'hFFFFFF, 24'h010101};
    tbl[13] = '{8'h01, 24'h807F00, 24'h000100};
    tbl[14] = '{8'h01, 24'h000000, 24'h000000};
    tbl[15] = '{8'h01, 24'h7F7F7F, 24'h000000};
    tbl[16] = '{8'h01, 24'hFF0080, 24'h000101};
    tbl[17] = '{8'h01, 24'h00FF00, 24'h010000};
    tbl[18] = '{8'h00, 24'hFFFFFF, 24'h000000};
    tbl[19] = '{8'h00, 24'hFF8040, 24'h000000};
    tbl[20] = '{8'h00, 24'h123456, 24'h000000};
    tbl[21] = '{8'h00, 24'h0000FF, 24'h000000};
    tbl[22] = '{8'h00, 24'hFF0000, 24'h000000};
    tbl[23] = '{8'h00, 24'h00FF00, 24'h000000};
    mem_a[0] = 24'h000000; mem_a[1] = 24'hFFFFFF; mem_a[2] = 24'h112233;
    mem_a[3] = 24'h445566; mem_a[4] = 24'h778899; mem_a[5] = 24'hAABBCC;
    mem_a[6] = 24'h0;      mem_a[7] = 24'h0;
    for (int i = 0; i < 8; i++) mem_b[i] = 24'h0;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    frame_go_a = 1'b0;
    frame_go_b = 1'b0;
    br_a = 8'hFF;
    br_b = 8'h00;
    repeat (3) @(negedge clk);
    check("a reset outputs", {27'd0, di_a, busy_a, rd_en_a, fd_a, 1'b0} | {29'd0, addr_a}, 0);
    check("b reset outputs", {27'd0, di_b, busy_b, rd_en_b, fd_b, 1'b0} | {29'd0, addr_b}, 0);
    @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    rel_cyc = cyc;
    fork
      seq_a();
      seq_b();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
